i2s_adc_receiver: RTL and testbench

//  I2S receiver for the codec ADC path (line-in/mic capture); the codec is I2S master and drives BCLK/ADCLRC.

---
 rtl/i2s_adc_receiver_if.sv | 43 ++++
 rtl/i2s_adc_receiver.sv | 220 ++++++++++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2s_adc_receiver_if
//  Description : Sample-buffer write port and full/release handshake between
//                the I2S ADC receiver and its buffer consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2s_adc_receiver_if #(
    parameter int SAMPLE_BITS      = 16,
    parameter int BUFFER_ADDR_BITS = 9
);
    logic [BUFFER_ADDR_BITS-1:0] address;
    logic [SAMPLE_BITS-1:0]      buffer_data_out;
    logic                        buffer_we_o;
    logic                        buffer_sel_o;
    logic                        buffer_full_o;
    logic                        overrun_o;
    logic                        buffer_released_i;

    // Receiver side: writes samples, reports buffer state, accepts releases
    modport master (
        output address,
        output buffer_data_out,
        output buffer_we_o,
        output buffer_sel_o,
        output buffer_full_o,
        output overrun_o,
        input  buffer_released_i
    );

    // Consumer side: observes writes and buffer state, releases halves
    modport slave (
        input  address,
        input  buffer_data_out,
        input  buffer_we_o,
        input  buffer_sel_o,
        input  buffer_full_o,
        input  overrun_o,
        output buffer_released_i
    );
endinterface
`default_nettype wire

// File: rtl/i2s_adc_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2s_adc_receiver
//  Description : Oversampling I2S slave receiver for the codec ADC path.
//                Deserialises left/right words and writes them interleaved
//                into a ping-pong sample buffer with a full/release handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_adc_receiver #(
    parameter int SAMPLE_BITS      = 16,
    parameter int BUFFER_ADDR_BITS = 9,
    parameter int BUFFER_WORDS     = 512
) (
    input  wire                   master_clock,
    input  wire                   reset_n,
    input  wire                   I2S_BCLK,
    input  wire                   I2S_ADCLRC,
    input  wire                   I2S_ADCDAT,
    i2s_adc_receiver_if.master    bus
);

    localparam int                    c_CNT_BITS  = $clog2(SAMPLE_BITS);
    localparam logic [c_CNT_BITS-1:0] c_LAST_BIT  = c_CNT_BITS'(SAMPLE_BITS - 1);
    localparam logic [BUFFER_ADDR_BITS-1:0] c_LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_WORDS - 1);

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [1:0]                  r_bclk_sync;
    logic [1:0]                  r_lrc_sync;
    logic [1:0]                  r_dat_sync;
    logic                        r_bclk_q;
    logic                        r_rise;
    logic                        r_lrc_d;
    logic                        r_dat_d;
    logic                        r_lrc_last;

    // MSB of the word is never stored here: it is taken straight from the
    // shift input when the final bit arrives.
    logic [SAMPLE_BITS-2:0]      r_shift;
    logic [c_CNT_BITS-1:0]       r_bit_cnt;

    logic                        r_we;
    logic [SAMPLE_BITS-1:0]      r_data;
    logic [BUFFER_ADDR_BITS-1:0] r_addr;
    logic                        r_sel;
    logic                        r_full;
    logic                        r_overrun;

    logic                        w_lrc_fall;
    logic                        w_lrc_edge;
    logic                        w_shift_en;
    logic                        w_capture;
    logic                        w_short;
    logic [SAMPLE_BITS-1:0]      w_word;
    logic                        w_wrap;
    logic                        w_full_kept;

    // Two-stage synchronisers plus a registered BCLK rise strobe; LRC and DATA
    // get one extra stage so they line up with the strobe.
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_bclk_sync <= 2'b00;
            r_lrc_sync  <= 2'b00;
            r_dat_sync  <= 2'b00;
            r_bclk_q    <= 1'b0;
            r_rise      <= 1'b0;
            r_lrc_d     <= 1'b0;
            r_dat_d     <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], I2S_BCLK};
            r_lrc_sync  <= {r_lrc_sync[0], I2S_ADCLRC};
            r_dat_sync  <= {r_dat_sync[0], I2S_ADCDAT};
            r_bclk_q    <= r_bclk_sync[1];
            r_rise      <= r_bclk_sync[1] & ~r_bclk_q;
            r_lrc_d     <= r_lrc_sync[1];
            r_dat_d     <= r_dat_sync[1];
        end
    end

    // Word-select level seen at the previous BCLK rise, for slot edge detection
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_lrc_last <= 1'b0;
        end else if (r_rise) begin
            r_lrc_last <= r_lrc_d;
        end
    end

    assign w_lrc_fall = r_rise & r_lrc_last & ~r_lrc_d;
    assign w_lrc_edge = r_rise & (r_lrc_last ^ r_lrc_d);
    assign w_word     = {r_shift, r_dat_d};

    // State register
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_state <= ALIGN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes. The rise that reveals an LRC edge is
    // itself the I2S delay bit, so it is consumed by the transition into
    // DELAY; DELAY then only clears the bit counter for one cycle.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_capture    = 1'b0;
        w_short      = 1'b0;
        case (r_state)
            ALIGN: begin
                if (w_lrc_fall) begin
                    w_state_next = DELAY;
                end
            end
            DELAY: begin
                w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_lrc_edge) begin
                    w_short      = 1'b1;
                    w_state_next = ALIGN;
                end else if (r_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_capture    = 1'b1;
                        w_state_next = PAD;
                    end
                end
            end
            PAD: begin
                if (w_lrc_edge) begin
                    w_state_next = DELAY;
                end
            end
            default: begin
                w_state_next = ALIGN;
            end
        endcase
    end

    // Serial-to-parallel shift register and bit counter
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == DELAY) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= w_word[SAMPLE_BITS-2:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // One-cycle write strobe carrying the completed word
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_we   <= 1'b0;
            r_data <= '0;
        end else begin
            r_we <= w_capture;
            if (w_capture) begin
                r_data <= w_word;
            end
        end
    end

    assign w_wrap      = r_we && (r_addr == c_LAST_ADDR);
    // A release in the completing cycle is applied before the completion
    assign w_full_kept = r_full & ~bus.buffer_released_i;

    // Address advance, half completion, release and overrun bookkeeping
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_sel     <= 1'b0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_we) begin
            if (w_wrap) begin
                r_addr <= '0;
                r_full <= 1'b1;
                if (w_full_kept) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_sel <= ~r_sel;
                end
            end else begin
                r_addr <= r_addr + 1'b1;
                r_full <= w_full_kept;
            end
        end else begin
            r_full <= w_full_kept;
            // A dropped right word leaves an odd address; skip its slot so the
            // next left word lands on an even address. Rounding past the last
            // word restarts the half without flagging it complete.
            if (w_short && r_addr[0]) begin
                r_addr <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign bus.address         = r_addr;
    assign bus.buffer_data_out = r_data;
    assign bus.buffer_we_o     = r_we;
    assign bus.buffer_sel_o    = r_sel;
    assign bus.buffer_full_o   = r_full;
    assign bus.overrun_o       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_adc_receiver
//  Description : Codec-driven bench for i2s_adc_receiver with a scoreboard of
//                expected buffer writes and a slot-level buffer-state model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_adc_receiver;

    localparam int BW = 8;

    logic master_clock = 1'b0;
    logic reset_n      = 1'b0;
    logic bclk         = 1'b0;
    logic lrc          = 1'b1;
    logic dat          = 1'b0;

    i2s_adc_receiver_if #(.SAMPLE_BITS(16), .BUFFER_ADDR_BITS(9)) bus ();

    i2s_adc_receiver #(
        .SAMPLE_BITS      (16),
        .BUFFER_ADDR_BITS (9),
        .BUFFER_WORDS     (BW)
    ) dut (
        .master_clock (master_clock),
        .reset_n      (reset_n),
        .I2S_BCLK     (bclk),
        .I2S_ADCLRC   (lrc),
        .I2S_ADCDAT   (dat),
        .bus          (bus)
    );

    always #5 master_clock = ~master_clock;

    int cyc = 0;
    always @(posedge master_clock) cyc <= cyc + 1;

    typedef struct {
        bit          marker;   // short slot while aligned: round address up
        logic [15:0] data;
        int          t16;      // cycle of the pin rise carrying the last bit
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Buffer-state model
    int m_addr = 0;
    bit m_sel  = 0;
    bit m_full = 0;
    bit m_ovr  = 0;
    bit chk_reset = 0;
    bit chk_addr  = 0;
    bit prev_we   = 0;

    // Codec-side knowledge of whether the receiver is locked to slots
    bit aligned         = 0;
    bit right_rise_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard and model, sampled mid-cycle
    always @(negedge master_clock) begin
        exp_t e;
        bit   still_full;
        check("flags", {29'd0, bus.buffer_sel_o, bus.buffer_full_o, bus.overrun_o},
                       {29'd0, m_sel, m_full, m_ovr});
        if (chk_reset) begin
            check("rst_addr", 32'(bus.address), 32'd0);
            check("rst_data", 32'(bus.buffer_data_out), 32'd0);
            check("rst_we", 32'(bus.buffer_we_o), 32'd0);
        end
        if (chk_addr) check("addr_next", 32'(bus.address), 32'(m_addr));
        chk_reset = 0;
        chk_addr  = 0;

        if (bus.buffer_we_o) begin
            check("we_width", 32'(prev_we), 32'd0);
            while (exp_q.size() > 0 && exp_q[0].marker) begin
                if (m_addr % 2 == 1) m_addr = (m_addr + 1) % BW;
                void'(exp_q.pop_front());
            end
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wdata", 32'(bus.buffer_data_out), 32'(e.data));
                check("waddr", 32'(bus.address), 32'(m_addr));
                check("latency", 32'(cyc - e.t16), 32'd4);
            end
        end

        if (!reset_n) begin
            m_addr = 0; m_sel = 0; m_full = 0; m_ovr = 0;
            exp_q.delete();
            chk_reset = 1;
        end else if (bus.buffer_we_o) begin
            still_full = m_full && !bus.buffer_released_i;
            if (m_addr == BW - 1) begin
                m_addr = 0;
                if (still_full) m_ovr = 1;
                else            m_sel = !m_sel;
                m_full = 1;
            end else begin
                m_addr = m_addr + 1;
                m_full = still_full;
            end
            chk_addr = 1;
        end else if (bus.buffer_released_i) begin
            m_full = 0;
        end
        prev_we = bus.buffer_we_o;
    end

    task automatic reset_pulse(input int n);
        reset_n = 1'b0;
        aligned = 0;
        right_rise_seen = 0;
        repeat (n) @(posedge master_clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic release_now();
        @(posedge master_clock);
        #1 bus.buffer_released_i = 1'b1;
        @(posedge master_clock);
        #1 bus.buffer_released_i = 1'b0;
    endtask

    // Release lands in the same cycle as the write strobe of the word whose
    // last bit rose just now (4 cycles of receiver latency).
    task automatic release_at_write();
        repeat (4) @(posedge master_clock);
        #1 bus.buffer_released_i = 1'b1;
        @(posedge master_clock);
        #1 bus.buffer_released_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge master_clock);
    endtask

    // One slot: bit 0 is the I2S delay bit, bits 1..16 the word MSB first,
    // the rest padding. BCLK = master/16, LRC and DATA change on BCLK fall.
    task automatic send_slot(input logic l, input int nbits, input logic [15:0] w,
                             input bit fire_rel, input bit rst_mid);
        logic d;
        exp_t e;
        if (l == 1'b0) aligned = right_rise_seen;
        for (int i = 0; i < nbits; i++) begin
            d = (i >= 1 && i <= 16) ? w[16 - i] : 1'($urandom);
            @(posedge master_clock);
            #1 bclk = 1'b0; lrc = l; dat = d;
            repeat (7) @(posedge master_clock);
            @(posedge master_clock);
            #1 bclk = 1'b1;
            if (l && reset_n) right_rise_seen = 1;
            if (i == 16 && nbits > 16 && aligned) begin
                e.marker = 0; e.data = w; e.t16 = cyc;
                exp_q.push_back(e);
                if (fire_rel) fork release_at_write(); join_none
            end
            if (i == 7 && rst_mid) fork reset_pulse(2); join_none
            repeat (7) @(posedge master_clock);
        end
        if (nbits < 17 && aligned) begin
            e.marker = 1; e.data = '0; e.t16 = 0;
            exp_q.push_back(e);
            aligned = 0;
            right_rise_seen = 0;
        end
    endtask

    task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                              input int nl, input int nr,
                              input bit fire_rel, input bit rst_mid);
        send_slot(1'b0, nl, lw, 1'b0, rst_mid);
        send_slot(1'b1, nr, rw, fire_rel, 1'b0);
    endtask

    task automatic rand_frames(input int n);
        for (int k = 0; k < n; k++)
            send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b0, 1'b0);
    endtask

    task automatic restart();
        @(posedge master_clock);
        #1 reset_pulse(4);
        idle(8);
        send_slot(1'b1, 12, 16'($urandom), 1'b0, 1'b0);   // join mid right slot
    endtask

    initial begin
        int left;
        bus.buffer_released_i = 1'b0;
        idle(5);
        #1 reset_n = 1'b1;
        idle(8);

        // Known pattern, then fill one half and release it
        send_slot(1'b1, 12, 16'($urandom), 1'b0, 1'b0);
        send_frame(16'hA5C3, 16'h0F0F, 32, 32, 1'b0, 1'b0);
        rand_frames(3);
        idle(20);
        release_now();
        idle(20);
        release_now();                                      // no effect when empty
        idle(20);

        // Two halves without release: overrun, same half rewritten
        restart();
        rand_frames(9);
        idle(20);

        // Release coinciding with half completion
        restart();
        rand_frames(7);
        send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b1, 1'b0);
        idle(20);

        // Short slots, then reset in the middle of a left word
        send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b0, 1'b0);
        send_frame(16'($urandom), 16'($urandom), 32, 10, 1'b0, 1'b0);
        rand_frames(2);
        send_frame(16'($urandom), 16'($urandom), 10, 32, 1'b0, 1'b0);
        rand_frames(2);
        send_frame(16'($urandom), 16'($urandom), 32, 32, 1'b0, 1'b1);
        rand_frames(2);
        idle(50);

        left = 0;
        foreach (exp_q[k]) if (!exp_q[k].marker) left++;
        check("writes_missing", 32'(left), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
